memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  EX/MEM pipeline register plus data-memory access FSM for the 16-bit MISC-V core; sits directly downstream of Execute_Stage.
//  Latches the execute results and drives a req/ack data-memory port for loads and stores.
//  Stalls upstream while an access is outstanding and exports MEM-stage forwarding values (ALUResultMEM, rdMEM).
// PARAMETERS
//  DW              16   datapath width (ALU result, store data, load data, PC+2)
//  RW              16   destination-register field width (matches Execute_Stage ORd)
//  TIMEOUT_CYCLES  64   watchdog limit in cycles; used only with MEM_TIMEOUT_EN
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   asynchronous, active-low reset
//  IRegWrite     in   1   from EX: writes register file
//  IMemWrite     in   1   from EX: store
//  IMemRead      in   1   from EX: load
//  IRegStore     in   1   from EX: writeback source select, passed through
//  IPCP2         in   DW  from EX: PC+2
//  IALUResult    in   DW  from EX: ALU result (memory address for loads/stores)
//  I3rdArg       in   DW  from EX: store data
//  IRd           in   RW  from EX: destination register
//  mem_rdata     in   DW  data memory read data; valid when mem_ack=1
//  mem_ack       in   1   data memory completes the current request
//  mem_req       out  1   request valid
//  mem_we        out  1   1=write, 0=read; qualified by mem_req
//  mem_addr      out  DW  address = latched ALU result
//  mem_wdata     out  DW  latched store data
//  stall         out  1   upstream hold: EX and earlier stages must not advance
//  ORegWrite     out  1   to MEM/WB; forced 0 while stall=1
//  ORegStore     out  1   to MEM/WB
//  OPCP2         out  DW  to MEM/WB
//  OALUResult    out  DW  to MEM/WB; also ALUResultMEM forwarding value
//  OLoadData     out  DW  to MEM/WB; captured load data, 0 for non-loads
//  ORd           out  RW  to MEM/WB; also rdMEM forwarding value
//  mem_err       out  1   sticky timeout flag; exists only with MEM_TIMEOUT_EN
// BEHAVIOUR
//  Reset (reset=0, async): all registers, outputs, and mem_err go to 0; FSM goes to IDLE. mem_req and stall drop immediately, including mid-access.
//  EX/MEM register loads all I* inputs on every rising edge with stall=0 and holds while stall=1.
//  FSM states: IDLE, REQ, DONE.
//   IDLE/DONE: on an edge with stall=0 -> REQ if the loaded op has IMemRead|IMemWrite, else IDLE.
//   REQ: mem_req=1, stall=1; on an edge with mem_ack=1 -> DONE.
//  Load data: on the acking edge, OLoadData <= mem_rdata for a read.
//  Stores and non-memory ops: OLoadData is cleared to 0 when the op loads.
//  mem_we = latched MemWrite. If MemRead and MemWrite are both set, the access is a write.
//  Latency:
//   Non-memory op: outputs valid the cycle after capture; no stall.
//   Memory op: stall lasts N cycles, where N>=1 is the number of REQ cycles until ack. Ack in the first REQ cycle gives exactly 1 stall cycle.
//  mem_req stays high until ack; mem_addr, mem_wdata and mem_we are stable for the whole request.
//  mem_ack outside REQ is ignored.
//  Back-to-back memory ops: DONE goes straight to REQ, giving one non-stalled cycle between accesses.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   A counter clears on entry to REQ and increments each REQ cycle.
//   On reaching TIMEOUT_CYCLES with no ack, the FSM goes to DONE with OLoadData=0 and ORegWrite forced to 0 for that op.
//   mem_err sets and stays set until reset.
//  MEM_TIMEOUT_EN undefined: no counter and no mem_err port; REQ waits for ack indefinitely.
// TESTING
//  ALU op with IRegWrite=1, IALUResult=16'h1234, IRd=3:
//   -> next cycle OALUResult=16'h1234, ORd=3, ORegWrite=1, stall=0, mem_req=0.
//  Load addr 16'h0040, ack after 3 REQ cycles with mem_rdata=16'hBEEF:
//   -> stall=1 for 3 cycles, mem_we=0; then OLoadData=16'hBEEF, ORegWrite=1.
//  Store addr 16'h0010, data 16'h00AA, ack in the first REQ cycle:
//   -> mem_we=1, mem_wdata=16'h00AA for 1 cycle, stall=1 for 1 cycle, OLoadData=0.
//  Two back-to-back loads with immediate ack:
//   -> two separate 1-cycle requests, the second address is latched only after the first completes, no data mixing.
//  reset=0 asserted in the 2nd REQ cycle of a load:
//   -> mem_req, stall and all outputs 0 at once; after release, FSM is IDLE and the next ALU op passes normally.
//  With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, load never acked:
//   -> after 4 REQ cycles, stall=0, mem_err=1, ORegWrite=0, OLoadData=0.

Source files
------------

// File: rtl/memory_stage.sv
// EX/MEM pipeline register and req/ack data-memory access FSM for the 16-bit MISC-V core.
// Optional request watchdog with sticky mem_err enabled by defining MEM_TIMEOUT_EN.
module memory_stage #(
    parameter int DW = 16,
    parameter int RW = 16
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IRegWrite,
    input  logic          IMemWrite,
    input  logic          IMemRead,
    input  logic          IRegStore,
    input  logic [DW-1:0] IPCP2,
    input  logic [DW-1:0] IALUResult,
    input  logic [DW-1:0] I3rdArg,
    input  logic [RW-1:0] IRd,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          stall,
    output logic          ORegWrite,
    output logic          ORegStore,
    output logic [DW-1:0] OPCP2,
    output logic [DW-1:0] OALUResult,
    output logic [DW-1:0] OLoadData,
    output logic [RW-1:0] ORd
`ifdef MEM_TIMEOUT_EN
    ,
    output logic          mem_err
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_next;

    logic          reg_write_q;
    logic          mem_write_q;
    logic          mem_read_q;
    logic          end_req;

    // The only stalling state is REQ, so stall and mem_req fall the moment reset clears the state.
    assign stall   = (state == REQ);
    assign mem_req = (state == REQ);
    assign mem_we  = mem_req & mem_write_q;

    assign mem_addr  = OALUResult;

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] req_cnt;
    logic          timeout_hit;
    logic          timed_out;

    assign timeout_hit = (state == REQ) && !mem_ack && (req_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign end_req     = mem_ack | timeout_hit;
    assign ORegWrite   = reg_write_q & ~stall & ~timed_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_cnt   <= '0;
            timed_out <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            if (state == REQ) begin
                req_cnt <= req_cnt + CW'(1);
            end else begin
                req_cnt <= '0;
            end
            if (!stall) begin
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
                mem_err   <= 1'b1;
            end
        end
    end
`else
    assign end_req   = mem_ack;
    assign ORegWrite = reg_write_q & ~stall;
`endif

    // NOTE: every variable assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = (IMemRead | IMemWrite) ? REQ : IDLE;
            REQ:        if (end_req) state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ORegStore   <= 1'b0;
            OPCP2       <= '0;
            OALUResult  <= '0;
            mem_wdata   <= '0;
            ORd         <= '0;
            OLoadData   <= '0;
        end else if (!stall) begin
            reg_write_q <= IRegWrite;
            mem_write_q <= IMemWrite;
            mem_read_q  <= IMemRead;
            ORegStore   <= IRegStore;
            OPCP2       <= IPCP2;
            OALUResult  <= IALUResult;
            mem_wdata   <= I3rdArg;
            ORd         <= IRd;
            OLoadData   <= '0;
        end else if (mem_ack && mem_read_q && !mem_write_q) begin
            // A read-and-write op is treated as a store, so only pure loads capture data.
            OLoadData <= mem_rdata;
        end
    end

endmodule
